// File: rtl/multicycle_controller_if.sv
// Signal bundle between the multicycle datapath and its control FSM.
// The datapath side (master) drives opcode/funct/zero; the controller (slave) drives the strobes and selects.
interface multicycle_controller_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       iord;
    logic       alusrca;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    modport master (
        output opcode, funct, zero,
        input  pcen, irwrite, regwrite, memwrite, iord, alusrca, regdst,
               memtoreg, alusrcb, pcsrc, alucontrol, state
    );

    modport slave (
        input  opcode, funct, zero,
        output pcen, irwrite, regwrite, memwrite, iord, alusrca, regdst,
               memtoreg, alusrcb, pcsrc, alucontrol, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for a MIPS-style multicycle datapath (lw/sw/R-type/beq/addi/j).
// Define MC_CTRL_JUMP_EN to implement the JEX state; otherwise opcode 000010 decodes as a NOP.
module multicycle_controller (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_controller_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MC_CTRL_JUMP_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
`ifdef MC_CTRL_JUMP_EN
        S_JEX     = 4'd11,
`endif
        S_ADDIWB  = 4'd10
    } state_t;

    state_t state_q, state_d;

    logic       pcwrite, branch;
    logic       irwrite_raw, regwrite_raw, memwrite_raw;
    logic       iord, alusrca, regdst, memtoreg;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
`ifdef MC_CTRL_JUMP_EN
                    OP_J:         state_d = S_JEX;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            // Terminal states and unused encodings all return to FETCH.
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        pcwrite      = 1'b0;
        branch       = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        memwrite_raw = 1'b0;
        iord         = 1'b0;
        alusrca      = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        alucontrol   = 3'b010;
        case (state_q)
            S_FETCH: begin
                alusrcb     = 2'b01;
                irwrite_raw = 1'b1;
                pcwrite     = 1'b1;
            end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                case (bus.funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            S_RTYPEWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                branch     = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: regwrite_raw = 1'b1;
`ifdef MC_CTRL_JUMP_EN
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Reset gates the write strobes immediately so an aborted instruction never commits.
    assign bus.pcen       = (pcwrite | (branch & bus.zero)) & ~reset;
    assign bus.irwrite    = irwrite_raw & ~reset;
    assign bus.regwrite   = regwrite_raw & ~reset;
    assign bus.memwrite   = memwrite_raw & ~reset;
    assign bus.iord       = iord;
    assign bus.alusrca    = alusrca;
    assign bus.regdst     = regdst;
    assign bus.memtoreg   = memtoreg;
    assign bus.alusrcb    = alusrcb;
    assign bus.pcsrc      = pcsrc;
    assign bus.alucontrol = alucontrol;
    assign bus.state      = state_q;
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The module SHALL have no parameters; every width is fixed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 opcode  in  6  instr[31:26] from the instruction register.
REQ-005 funct  in  6  instr[5:0] from the instruction register.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 pcen  out  1  PC register enable.
REQ-008 irwrite, regwrite, memwrite  out  1 each  IR, register-file and memory write strobes.
REQ-009 iord, alusrca, regdst, memtoreg  out  1 each  mux selects.
REQ-010 alusrcb  out  2  B-operand select: 00=reg B, 01=const 4, 10=sign-ext imm, 11=imm<<2.
REQ-011 pcsrc  out  2  next-PC select: 00=ALU result, 01=ALUOut, 10=jump target.
REQ-012 alucontrol  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-013 state  out  4  current FSM state, for debug.

Function
REQ-014 The FSM SHALL be Moore, with a registered state and combinational outputs decoded from state, except pcen.
REQ-015 States and encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
REQ-016 State transitions:
- FETCH->DECODE.
- DECODE by opcode: 100011/101011->MEMADR; 000000->RTYPEEX; 000100->BEQEX; 001000->ADDIEX; 000010->JEX.
- MEMADR->MEMRD for lw, ->MEMWR for sw.
- MEMRD->MEMWB.
- RTYPEEX->RTYPEWB.
- ADDIEX->ADDIWB.
- MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX->FETCH.
REQ-017 In DECODE, any other opcode SHALL be treated as a NOP: the next state is FETCH and no write strobe is asserted.
REQ-018 Encodings 12-15 SHALL go to FETCH on the next edge with all strobes at 0.
REQ-019 Outputs per state; every signal not listed is 0 and alucontrol defaults to 010:
- FETCH: alusrcb=01, irwrite=1, pcwrite=1.
- DECODE: alusrcb=11.
- MEMADR: alusrca=1, alusrcb=10.
- MEMRD: iord=1.
- MEMWB: memtoreg=1, regwrite=1.
- MEMWR: iord=1, memwrite=1.
- RTYPEEX: alusrca=1, alucontrol from funct.
- RTYPEWB: regdst=1, regwrite=1.
- BEQEX: alusrca=1, alucontrol=110, pcsrc=01, branch=1.
- ADDIEX: alusrca=1, alusrcb=10.
- ADDIWB: regwrite=1.
- JEX: pcsrc=10, pcwrite=1.
REQ-020 The funct decode in RTYPEEX SHALL map 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; any other funct->010.
REQ-021 pcen SHALL equal pcwrite OR (branch AND zero), combinationally within the same cycle.
REQ-022 Instruction latencies in cycles, counted FETCH to FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, NOP 2.
REQ-023 opcode and funct SHALL be sampled only in DECODE, MEMADR and RTYPEEX; changes in any other state SHALL have no effect.

Reset
REQ-024 While reset=1 at a rising edge, the state register SHALL load FETCH.
REQ-025 While reset=1, pcen, irwrite, regwrite and memwrite SHALL be forced to 0 irrespective of state.
REQ-026 Reset asserted mid-instruction, including in MEMWR or RTYPEWB, SHALL abort it with no write strobe asserted in that cycle.
REQ-027 The first cycle after reset deasserts SHALL be FETCH, with irwrite=1 and pcen=1.

Configuration
REQ-028 Macro MC_CTRL_JUMP_EN defined: JEX is implemented and opcode 000010 executes the jump.
REQ-029 Macro MC_CTRL_JUMP_EN undefined: JEX is absent, opcode 000010 is a NOP (DECODE->FETCH), and pcsrc is never 10.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- reset=1 for 2 cycles, then release -> state=0, irwrite=1, pcen=1 on the first free cycle; all strobes 0 during reset.
- opcode=000000, funct=101010 -> states 0,1,6,7,0; alucontrol=111 in RTYPEEX; regwrite=1, regdst=1 only in RTYPEWB.
- opcode=100011 -> states 0,1,2,3,4,0; iord=1 in MEMRD; memtoreg=1, regwrite=1 in MEMWB.
- opcode=000100 with zero=1 -> pcen=1 and pcsrc=01 in BEQEX; repeated with zero=0 -> pcen=0; both return to FETCH after 3 cycles.
- opcode=101011, reset asserted during MEMWR -> memwrite=0 that cycle, state=0 next.
- opcode=000010 -> with MC_CTRL_JUMP_EN, states 0,1,11,0 with pcsrc=10 and pcen=1; without it, states 0,1,0 and pcen=0 in DECODE.
